// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//
// Multi-cycle fetch/decode/execute/writeback controller for a 4-bit
// processor. It fetches 8-bit instructions from an external instruction
// memory and holds a 4-entry x 4-bit register file. For ADD/SUB it drives
// the operands and opcode of an external 4-bit ALU, then captures the ALU
// result and writes it back.
//
// Instruction encoding (imem_data):
//   [7:6] 00 LDI  rd=[5:4] imm4=[3:0]
//         01 ADD  rd=[5:4] rs=[3:2] rt=[1:0]
//         10 SUB  rd=[5:4] rs=[3:2] rt=[1:0]
//         11 HALT
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        run request
//   imem_addr    instruction address (registered PC)
//   imem_data    instruction word, combinational read of imem_addr
//   alu_a/alu_b  registered ALU operands
//   alu_op       registered ALU opcode (0 = ADD, 1 = SUB)
//   alu_result   ALU result, combinational from alu_a/alu_b/alu_op
//   busy         high in FETCH/DECODE/EXECUTE/WRITEBACK
//   done         one-cycle pulse on entry to HALTED
//   instr_count  retired-instruction counter, saturates at 255
//   dbg_sel      register-file debug read select
//   dbg_data     combinational read of reg[dbg_sel]
//   dbg_state    current FSM state, for observation only
//
// Handshake: start is a plain level request with no acknowledge. It is
// sampled on a rising edge only while the sequencer is in IDLE or HALTED;
// at any other time it has no effect. Completion is signalled by the done
// pulse, and busy reports whether a program is running.

module cpu_sequencer #(
    parameter int IMEM_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [7:0]         imem_data,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic               alu_op,
    input  logic [3:0]         alu_result,
    output logic               busy,
    output logic               done,
    output logic [7:0]         instr_count,
    input  logic [1:0]         dbg_sel,
    output logic [3:0]         dbg_data,
    output logic [2:0]         dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    logic [2:0]         state;
    logic [IMEM_AW-1:0] pc;
    logic [7:0]         ir;
    logic [3:0]         result_q;
    logic [3:0]         regs [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            result_q    <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= 1'b0;
            done        <= 1'b0;
            instr_count <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // done is a pulse: only the HALT decode raises it.
            done <= 1'b0;
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc          <= '0;
                        instr_count <= '0;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir    <= imem_data;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (ir[7:6])
                        OP_LDI: begin
                            result_q <= ir[3:0];
                            state    <= S_WB;
                        end
                        OP_ADD, OP_SUB: begin
                            // Operands are captured here, before any write,
                            // so rs/rt may alias rd.
                            alu_a  <= regs[ir[3:2]];
                            alu_b  <= regs[ir[1:0]];
                            alu_op <= ir[7];
                            state  <= S_EXEC;
                        end
                        OP_HALT: begin
                            done  <= 1'b1;
                            state <= S_HALTED;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
                S_EXEC: begin
                    // ALU has had a full cycle to settle on the registered operands.
                    result_q <= alu_result;
                    state    <= S_WB;
                end
                S_WB: begin
                    regs[ir[5:4]] <= result_q;
                    pc            <= pc + 1'b1;
                    if (instr_count != 8'hFF) begin
                        instr_count <= instr_count + 8'd1;
                    end
                    state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign imem_addr = pc;
    assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                       (state == S_EXEC)  || (state == S_WB);
    assign dbg_data  = regs[dbg_sel];
    assign dbg_state = state;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle fetch/decode/execute/writeback controller for the 4-bit processor datapath. It fetches 8-bit instructions from an external instruction memory and holds a 4-entry × 4-bit register file. It drives the operand and opcode inputs of the downstream 4-bit ADD/SUB ALU, then captures the ALU result and writes it back. It is the stage directly upstream of the ALU and also consumes its result.

## Interface
- IMEM_AW, 4, instruction memory address width; PC wraps modulo 2^IMEM_AW
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  run request, sampled only in IDLE or HALTED
- imem_addr  output  IMEM_AW  instruction address (registered PC)
- imem_data  input  8  instruction word, combinational read of imem_addr
- alu_a  output  4  registered ALU operand a
- alu_b  output  4  registered ALU operand b
- alu_op  output  1  registered ALU opcode; 0 = ADD, 1 = SUB
- alu_result  input  4  ALU result, combinational from alu_a/alu_b/alu_op
- busy  output  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
- done  output  1  one-cycle pulse on entry to HALTED
- instr_count  output  8  retired-instruction counter, saturates at 255
- dbg_sel  input  2  register-file debug read select
- dbg_data  output  4  combinational read of reg[dbg_sel]

## Operation
- Encoding imem_data[7:6]: 00 LDI, 01 ADD, 10 SUB, 11 HALT.
- LDI: rd = [5:4], imm4 = [3:0]. ADD/SUB: rd = [5:4], rs = [3:2], rt = [1:0]. HALT ignores [5:0].
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
- IDLE or HALTED with start=1: PC←0, instr_count←0, go to FETCH. Register file is retained.
- FETCH: latch imem_data into the instruction register; go to DECODE.
- DECODE, by op:
  - ADD/SUB: alu_a←reg[rs], alu_b←reg[rt], alu_op←op[1]; go to EXECUTE.
  - LDI: result_q←imm4; go to WRITEBACK.
  - HALT: go to HALTED, done←1 for one cycle. PC and instr_count are unchanged.
- EXECUTE: result_q←alu_result; go to WRITEBACK.
- WRITEBACK: reg[rd]←result_q; PC←PC+1 with wrap; instr_count←min(instr_count+1, 255); go to FETCH.
- Arithmetic is performed by the ALU, 4-bit and truncated. No carry or borrow is produced or stored.
- rs == rd or rt == rd is legal: operands are latched in DECODE, before the write.
- r0 is an ordinary writable register.
- start while busy is ignored. start in the same cycle as a HALT decode is ignored.
- alu_a/alu_b/alu_op hold their values outside DECODE.
- Reset at any time, including mid-instruction: state→IDLE and all registers and outputs cleared. The pending writeback is discarded.

## Timing
- Reset values: imem_addr=0, alu_a=0, alu_b=0, alu_op=0, busy=0, done=0, instr_count=0, all reg[*]=0, state IDLE.
- Cycle counts (edge on which start is sampled = edge 0):
  - LDI: 3 cycles (FETCH, DECODE, WRITEBACK).
  - ADD/SUB: 4 cycles.
  - HALT: 2 cycles, then HALTED.
- Register write becomes visible on dbg_data the cycle after WRITEBACK.
- alu_result is sampled at the end of EXECUTE, one full cycle after the operands are registered.
- busy goes high the cycle after start is sampled. busy goes low in the cycle done is high.
- done is high exactly one cycle, then HALTED persists with done=0.

## Test plan
- Reset then idle: all outputs are 0, busy=0. start pulse → busy=1 next cycle, imem_addr=0.
- Program LDI r1,3; LDI r2,5; ADD r3,r1,r2; HALT:
  - done high in cycle 13 after start.
  - r3=8, instr_count=3, imem_addr=3.
- Program LDI r0,2; LDI r1,5; SUB r2,r0,r1; ADD r3,r3,r3 (r3 preset 9 by LDI); HALT:
  - r2=0xD (wrap).
  - r3=2 (18 truncated).
  - alu_op=1 during the SUB EXECUTE.
- 16 consecutive LDI instructions with no HALT: after the 16th WRITEBACK, imem_addr=0 and instr_count=16. Execution continues.
- Assert rst_n low in EXECUTE of an ADD → immediately IDLE. Destination register is unchanged (0), alu_a=0, busy=0.
- start pulses while busy are ignored (PC is not reset). start in HALTED restarts at PC=0 with registers retained.
